// File: rtl/lc3_fetch_pkg.sv
// lc3_fetch_pkg: shared LC3 fetch widths, reset vector and queue entry type
package lc3_fetch_pkg;
  localparam int LC3_ADDR_W = 16;
  localparam int LC3_DATA_W = 16;
  localparam logic [15:0] LC3_RESET_PC = 16'h3000;
  typedef struct packed {
    logic [LC3_ADDR_W-1:0] pc;
    logic [LC3_DATA_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of fetched words with synchronous flush
module fetch_fifo
  import lc3_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wdata,
  output entry_t                 rdata,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  entry_t mem [DEPTH];
  logic [PW-1:0] rd, wr;
  logic wen, ren;
  // a flush voids any push or pop in the same cycle
  assign wen = push & ~flush;
  assign ren = pop & ~flush;
  assign rdata = mem[rd];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      rd <= rd + PW'(ren);
      wr <= wr + PW'(wen);
      count <= count + CW'(wen) - CW'(ren);
    end
  end
  always_ff @(posedge clk) if (wen) mem[wr] <= wdata;
  always_ff @(posedge clk) if (!rst) assert (!(wen && !ren && count == CW'(DEPTH)));
endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential imem prefetch into a queue feeding decode, with redirect
module fetch_prefetch_queue
  import lc3_fetch_pkg::*;
#(
  parameter int ADDR_W = LC3_ADDR_W,
  parameter int DATA_W = LC3_DATA_W,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(LC3_RESET_PC)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable_fetch,
  input  logic                   br_taken,
  input  logic [ADDR_W-1:0]      taddr,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [DATA_W-1:0]      imem_rdata,
  output logic                   instr_valid,
  output logic [DATA_W-1:0]      instr,
  output logic [ADDR_W-1:0]      pc,
  output logic [ADDR_W-1:0]      npc_out,
  input  logic                   instr_ready,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] CAP = SW'(DEPTH);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;
  logic [ADDR_W-1:0] fetch_pc, resp_pc;
  logic [CW-1:0] outstanding, discard;
  logic xfer, rsp, drop, push, pop;
  entry_t head, wentry;
  // buffered plus in-flight words never exceed DEPTH, so pushes cannot overflow
  assign imem_req = enable_fetch & ~reset & ~br_taken & (({1'b0, count} + {1'b0, outstanding}) < CAP);
  assign imem_addr = fetch_pc;
  assign xfer = imem_req & imem_gnt;
  assign rsp = imem_rvalid & (outstanding != '0);
  assign drop = rsp & (discard != '0);
  assign push = rsp & ~drop;
  assign pop = instr_valid & instr_ready;
  assign wentry = '{pc: resp_pc, instr: imem_rdata};
  assign instr_valid = count != '0;
  assign instr = head.instr;
  assign pc = head.pc;
  assign npc_out = head.pc + ADDR_W'(1);
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      discard <= '0;
    end else if (br_taken) begin
      fetch_pc <= taddr;
      resp_pc <= taddr;
      outstanding <= outstanding - CW'(rsp);
      discard <= outstanding - CW'(rsp);
    end else begin
      fetch_pc <= fetch_pc + ADDR_W'(xfer);
      resp_pc <= resp_pc + ADDR_W'(push);
      outstanding <= outstanding + CW'(xfer) - CW'(rsp);
      discard <= discard - CW'(drop);
    end
  end
  always_ff @(posedge clock) if (!reset) assert (!(imem_rvalid && outstanding == '0));
  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk  (clock),
    .rst  (reset),
    .flush(br_taken),
    .push (push),
    .pop  (pop),
    .wdata(wentry),
    .rdata(head),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue: directed checks with an in-order variable-latency memory model
module tb_fetch_prefetch_queue;
  logic clock = 0, reset = 1, enable_fetch = 0, br_taken = 0;
  logic [15:0] taddr = 0, imem_addr, imem_rdata = 0, instr, pc, npc_out;
  logic imem_req, imem_gnt = 1, imem_rvalid = 0, instr_valid, instr_ready = 0;
  logic [2:0] count;
  int total = 0, bad = 0, lat = 1, cycn = 0;
  typedef struct {logic [15:0] a; int due;} req_t;
  req_t pend[$];
  fetch_prefetch_queue dut (
    .clock(clock), .reset(reset), .enable_fetch(enable_fetch), .br_taken(br_taken),
    .taddr(taddr), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .pc(pc), .npc_out(npc_out), .instr_ready(instr_ready), .count(count)
  );
  always #5 clock = ~clock;
  function automatic logic [15:0] word(logic [15:0] a);
    return a ^ 16'hBEEF;
  endfunction
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    logic take;
    logic [15:0] a;
    #1;
    take = imem_req & imem_gnt;
    a = imem_addr;
    @(posedge clock);
    #1;
    cycn++;
    if (reset) pend.delete();
    else begin
      if (imem_rvalid) void'(pend.pop_front());
      if (take) pend.push_back('{a, cycn + lat - 1});
    end
    imem_rvalid = pend.size() > 0 && pend[0].due <= cycn;
    imem_rdata = imem_rvalid ? word(pend[0].a) : 16'h0;
    @(negedge clock);
  endtask
  task automatic do_reset();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int n;
    @(negedge clock);
    cyc();
    cyc();
    check("rst_count", count, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_req", imem_req, 0);
    // streaming with 1-cycle memory
    enable_fetch = 1; instr_ready = 1; lat = 1;
    do_reset();
    check("s1_req0", imem_req, 1);
    check("s1_addr0", imem_addr, 16'h3000);
    cyc();
    check("s1_fill_valid", instr_valid, 0);
    check("s1_addr1", imem_addr, 16'h3001);
    cyc();
    for (int i = 0; i < 6; i++) begin
      check("s1_valid", instr_valid, 1);
      check("s1_pc", pc, 16'h3000 + i);
      check("s1_instr", instr, word(16'h3000 + i));
      check("s1_npc", npc_out, 16'h3001 + i);
      check("s1_addr", imem_addr, 16'h3002 + i);
      cyc();
    end
    // decode stall fills the queue to DEPTH
    instr_ready = 0;
    do_reset();
    for (int i = 0; i < 10; i++) cyc();
    check("s2_count", count, 4);
    check("s2_req", imem_req, 0);
    check("s2_pc", pc, 16'h3000);
    instr_ready = 1;
    for (int i = 0; i < 8; i++) begin
      check("s2_valid", instr_valid, 1);
      check("s2_pc_seq", pc, 16'h3000 + i);
      cyc();
    end
    // redirect with three in flight on a 3-cycle memory
    lat = 3;
    do_reset();
    for (int i = 0; i < 4; i++) cyc();
    check("s3_pre_count", count, 1);
    check("s3_pre_pc", pc, 16'h3000);
    br_taken = 1; taddr = 16'h4000;
    #1;
    check("s3_br_req", imem_req, 0);
    cyc();
    br_taken = 0;
    #1;
    check("s3_flush_count", count, 0);
    check("s3_flush_valid", instr_valid, 0);
    check("s3_new_addr", imem_addr, 16'h4000);
    n = 0;
    while (!instr_valid && n < 12) begin
      cyc();
      n++;
    end
    check("s3_wait", n < 12, 1);
    check("s3_pc", pc, 16'h4000);
    check("s3_instr", instr, word(16'h4000));
    // address wrap at FFFF
    lat = 1; instr_ready = 0;
    do_reset();
    br_taken = 1; taddr = 16'hFFFF;
    cyc();
    br_taken = 0;
    #1;
    check("s4_addr_ffff", imem_addr, 16'hFFFF);
    cyc();
    check("s4_addr_wrap", imem_addr, 16'h0000);
    cyc();
    check("s4_valid", instr_valid, 1);
    check("s4_pc", pc, 16'hFFFF);
    check("s4_npc", npc_out, 16'h0000);
    // fetch disabled with two in flight
    lat = 3; instr_ready = 1;
    do_reset();
    cyc();
    cyc();
    enable_fetch = 0;
    #1;
    check("s5_req_off", imem_req, 0);
    cyc();
    check("s5_d_valid", instr_valid, 0);
    cyc();
    check("s5_e_valid", instr_valid, 1);
    check("s5_e_pc", pc, 16'h3000);
    check("s5_e_req", imem_req, 0);
    cyc();
    check("s5_f_valid", instr_valid, 1);
    check("s5_f_pc", pc, 16'h3001);
    cyc();
    check("s5_g_valid", instr_valid, 0);
    check("s5_g_count", count, 0);
    check("s5_g_req", imem_req, 0);
    // reset mid-stream
    enable_fetch = 1; instr_ready = 0; lat = 1;
    do_reset();
    for (int i = 0; i < 4; i++) cyc();
    check("s6_count3", count, 3);
    reset = 1;
    #1;
    check("s6_rst_req", imem_req, 0);
    cyc();
    check("s6_count", count, 0);
    check("s6_valid", instr_valid, 0);
    check("s6_addr", imem_addr, 16'h3000);
    reset = 0;
    #1;
    check("s6_req_after", imem_req, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Parametrised successor to the LC3 single-PC fetch stage.
- Issues sequential instruction-memory requests over a req/gnt/rvalid handshake and buffers returned words with their PCs in a DEPTH-entry queue.
- Presents the buffered words to decode over a valid/ready handshake.
- Supports branch redirect with queue flush and discard of in-flight responses; sits between instruction memory and decode.

Parameters:
- ADDR_W, 16, PC and memory address width.
- DATA_W, 16, instruction word width.
- DEPTH, 4, queue entries (power of 2, >=2); also caps in-flight plus buffered words.
- RESET_PC, 16'h3000, fetch address after reset.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- enable_fetch  in  1  permits new memory requests.
- br_taken  in  1  redirect: flush and restart at taddr.
- taddr  in  ADDR_W  redirect target.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  request address (= fetch_pc).
- imem_gnt  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  in-order response valid.
- imem_rdata  in  DATA_W  response word.
- instr_valid  out  1  queue head valid.
- instr  out  DATA_W  head instruction.
- pc  out  ADDR_W  address of head instruction.
- npc_out  out  ADDR_W  pc+1, modulo 2^ADDR_W.
- instr_ready  in  1  decode accepts head.
- count  out  $clog2(DEPTH)+1  buffered entries.

Behaviour:
- Clock and reset: one clock, `clock`; `reset` is synchronous and active-high.
- Reset values: fetch_pc=RESET_PC, outstanding=0, discard=0, count=0, rd/wr pointers=0, instr_valid=0, imem_req=0. instr, pc and npc_out are don't-care while instr_valid=0.
- Issue:
  - imem_req = enable_fetch & ~reset & ~br_taken & (count+outstanding < DEPTH).
  - Combinational from registered state and these inputs only; no path from instr_ready.
  - Transfer when imem_req & imem_gnt: fetch_pc <= fetch_pc+1 (wraps 16'hFFFF->16'h0000), outstanding++.
  - imem_gnt without imem_req is ignored.
- Response:
  - On imem_rvalid: outstanding--.
  - If discard>0: discard--, word dropped. Otherwise push {resp_pc, imem_rdata}.
  - resp_pc is a separate counter that tracks the request stream and is reloaded on redirect.
  - imem_rvalid with outstanding==0 is a protocol error: ignored, flagged by an assertion.
- Dequeue:
  - instr_valid = (count!=0).
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - The issue cap guarantees no overflow; an overflow assertion is required.
- Latency: with a memory that grants immediately and returns rvalid the next cycle:
  - First request is issued in the first cycle after reset deasserts.
  - instr_valid=1 two cycles after that request.
  - Sustained one instruction per cycle requires DEPTH>=3.
- Redirect (br_taken=1):
  - Queue cleared: count=0, pointers=0, any pop or push that cycle is void.
  - fetch_pc <= taddr and resp_pc <= taddr.
  - discard <= outstanding - imem_rvalid, so every response to a pre-redirect request is dropped.
  - No request is issued in the redirect cycle.
  - A redirect during an active discard is handled by the same equation.
- enable_fetch=0: no new requests. In-flight responses still complete and queue; decode may drain.
- Reset mid-operation: all state returns to reset values next edge. Responses arriving after reset are not discarded; the memory must also be reset.

Decomposition:
- Package lc3_fetch_pkg holds:
  - RESET_PC default (16'h3000).
  - LC3 ADDR_W/DATA_W constants.
  - fetch_entry_t struct {pc, instr}.
- Sub-module fetch_fifo:
  - DEPTH x fetch_entry_t storage.
  - Read and write pointers with wrap.
  - count, synchronous flush.
- The top level owns fetch_pc, resp_pc, outstanding, discard, and the issue logic.

Test Plan:
- Reset release, enable_fetch=1, 1-cycle memory, instr_ready=1 -> imem_addr 3000,3001,3002...; pc/instr stream 3000,3001... one per cycle after a 2-cycle fill; npc_out=pc+1.
- instr_ready=0 for 10 cycles, DEPTH=4 -> imem_req drops once count+outstanding=4; count=4; no word lost; resumes in order when ready rises.
- Memory with 3-cycle response latency, 3 requests in flight, br_taken with taddr=16'h4000 -> queue empties that cycle; 3 stale responses dropped; next instr_valid has pc=4000.
- fetch_pc=16'hFFFF -> next request 16'h0000; head pc FFFF shows npc_out=0000.
- enable_fetch deasserted with 2 in flight -> both words queued, no further imem_req, instr_valid falls after drain.
- Reset asserted mid-stream with count=3 -> next cycle count=0, instr_valid=0, imem_addr=3000.
